// File: rtl/yaw_heading_integ.sv
// Yaw-rate heading integrator.
// Calibrates a zero-rate offset over 2^CAL_SHIFT samples. It then integrates the
// offset-corrected, saturated and deadbanded rate into a 27-bit wrapping integrator.
// The 12-bit heading is taken from integrator bits [26:15].
// Optional macro IR_FUSION_EN: guardrail sensors nudge the integrator by +/-1024 per update.
module yaw_heading_integ #(
    parameter int unsigned FAST_SIM = 1,
    parameter int unsigned DEADBAND = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_strt_cal,
    input  logic        i_vld,
    input  logic [15:0] i_yaw_rt,
    input  logic        i_moving,
    input  logic        i_lft_ir,
    input  logic        i_rght_ir,
    output logic        o_cal_done,
    output logic [11:0] o_heading,
    output logic        o_rdy
);

    localparam int unsigned CAL_SHIFT = (FAST_SIM != 0) ? 8 : 11;
    localparam logic [10:0] CAL_LAST  = 11'((1 << CAL_SHIFT) - 1);

    typedef enum logic [1:0] {StIdle, StCal, StRun} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic signed [26:0] r_cal_acc;
    logic [10:0]        r_count;
    logic [15:0]        r_offset;
    logic [26:0]        r_integ;
    logic               r_s1_vld;
    logic [15:0]        r_s1_comp;
    logic               r_rdy;
    logic               r_cal_done;

    logic               w_cal_last;
    logic               w_run;
    logic signed [26:0] w_cal_sum;
    logic [15:0]        w_cal_avg;
    logic [16:0]        w_diff;
    logic signed [15:0] w_sat;
    logic               w_in_band;
    logic [15:0]        w_comp;
    logic [26:0]        w_ir;
    logic [26:0]        w_integ_next;

    // Last calibration sample: strt_cal wins, so a restart never completes calibration.
    assign w_cal_last = (r_state == StCal) && i_vld && !i_strt_cal && (r_count == CAL_LAST);
    // Samples enter the pipeline only in RUN and never alongside a restart.
    assign w_run      = (r_state == StRun) && !i_strt_cal;

    assign w_cal_sum  = r_cal_acc + {{11{i_yaw_rt[15]}}, i_yaw_rt};
    assign w_cal_avg  = 16'(w_cal_sum >>> CAL_SHIFT);

    // 17-bit difference so the overflow can be seen and clamped.
    assign w_diff     = {i_yaw_rt[15], i_yaw_rt} - {r_offset[15], r_offset};

    // Saturate the corrected rate to the signed 16-bit range.
    always_comb begin
        w_sat = w_diff[15:0];
        if (w_diff[16] != w_diff[15]) begin
            w_sat = w_diff[16] ? 16'sh8000 : 16'sh7FFF;
        end
    end

    assign w_in_band  = (int'(w_sat) <= int'(DEADBAND)) && (int'(w_sat) >= -int'(DEADBAND));
    assign w_comp     = (w_in_band || !i_moving) ? 16'h0000 : w_sat;

`ifdef IR_FUSION_EN
    logic r_s1_moving;
    logic r_s1_lft;
    logic r_s1_rght;

    // Guardrail terms travel with their sample through stage 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_moving <= 1'b0;
            r_s1_lft    <= 1'b0;
            r_s1_rght   <= 1'b0;
        end else if (w_run && i_vld) begin
            r_s1_moving <= i_moving;
            r_s1_lft    <= i_lft_ir;
            r_s1_rght   <= i_rght_ir;
        end
    end

    // One-sided guardrail hit steers the heading away from that rail.
    always_comb begin
        w_ir = 27'd0;
        if (r_s1_moving && r_s1_lft && !r_s1_rght) begin
            w_ir = 27'd1024;
        end else if (r_s1_moving && r_s1_rght && !r_s1_lft) begin
            w_ir = -27'd1024;
        end
    end
`else
    logic w_unused_ir;
    assign w_unused_ir = i_lft_ir ^ i_rght_ir;
    assign w_ir        = 27'd0;
`endif

    assign w_integ_next = r_integ + {{11{r_s1_comp[15]}}, r_s1_comp} + w_ir;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; strt_cal always (re)enters calibration.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_strt_cal) w_state_next = StCal;
            StCal: begin
                if (i_strt_cal) begin
                    w_state_next = StCal;
                end else if (w_cal_last) begin
                    w_state_next = StRun;
                end
            end
            StRun:   if (i_strt_cal) w_state_next = StCal;
            default: w_state_next = StIdle;
        endcase
    end

    // Calibration accumulator, offset, two-stage integrator pipeline and strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cal_acc  <= '0;
            r_count    <= '0;
            r_offset   <= '0;
            r_integ    <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_comp  <= '0;
            r_rdy      <= 1'b0;
            r_cal_done <= 1'b0;
        end else begin
            r_rdy      <= 1'b0;
            r_cal_done <= 1'b0;
            if (i_strt_cal) begin
                r_cal_acc <= '0;
                r_count   <= '0;
            end else if (r_state == StCal && i_vld) begin
                r_cal_acc <= w_cal_sum;
                r_count   <= r_count + 11'd1;
                if (w_cal_last) begin
                    r_offset   <= w_cal_avg;
                    r_integ    <= '0;
                    r_cal_done <= 1'b1;
                end
            end
            // A restart flushes stage 1 and suppresses the pending stage-2 update.
            r_s1_vld <= w_run && i_vld;
            if (w_run && i_vld) begin
                r_s1_comp <= w_comp;
            end
            if (w_run && r_s1_vld) begin
                r_integ <= w_integ_next;
                r_rdy   <= 1'b1;
            end
        end
    end

    assign o_heading  = r_integ[26:15];
    assign o_rdy      = r_rdy;
    assign o_cal_done = r_cal_done;

endmodule
